frame_tx: RTL and testbench
===========================

// Module: frame_tx
// PURPOSE
//  Asynchronous serial transmitter for the 10-bit frame link. It latches a parallel payload on a
//  rising edge of tx_start and serialises it onto a single line: start bit, payload LSB first,
//  optional even parity, then stop bit(s). It drives the line that the link receiver samples.
//  It sits between the switch/button inputs and the serial connection in the transmission unit.
// PARAMETERS
//  CLKS_PER_BIT  5208  clk cycles per bit period (50 MHz / 9600 Bd); must be >= 2
//  DATA_W        10    payload width in bits
//  PARITY_EN     1     1 = append even-parity bit after data; 0 = no parity bit
//  STOP_BITS     1     number of stop bits, 1 or 2
// PORTS
//  clk       in   1       system clock; all logic is on the rising edge
//  rst       in   1       synchronous, active-high reset
//  tx_start  in   1       start request; only a 0->1 transition is acted on (already synchronised)
//  tx_pi     in   DATA_W  parallel payload; sampled only on the accept cycle
//  Tx        out  1       serial line; idle high
//  Busy      out  1       high while a frame is on the line
//  Done      out  1       one-cycle pulse when a frame completes
// BEHAVIOUR
//  - Reset: Tx=1, Busy=0, Done=0, state=IDLE, counters=0, edge register=0. Reset mid-frame aborts
//    the frame: Tx is 1 on the next cycle and no Done pulse is produced.
//  - Edge detect: start_q <= tx_start every cycle. rise = tx_start & ~start_q. Holding tx_start high
//    does not retrigger.
//  - Accept: a rise sampled in IDLE latches tx_pi into the shift register and computes
//    parity = ^tx_pi. On that clock edge Tx<=0 and Busy<=1, so the start bit begins on the next cycle.
//  - A rise while Busy is dropped and not queued. Changes on tx_pi while Busy have no effect.
//  - FSM: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE.
//  - Each bit is held for exactly CLKS_PER_BIT cycles, timed by a bit counter of width
//    $clog2(CLKS_PER_BIT). The counter clears on every bit boundary. DATA uses a bit index of
//    width $clog2(DATA_W) and advances from 0 to DATA_W-1. It shifts right and Tx = shreg[0].
//  - PARITY: Tx = even parity of the latched payload, so the total number of 1s across data and
//    parity is even.
//  - STOP: Tx = 1 for STOP_BITS*CLKS_PER_BIT cycles.
//  - End of frame: on the last stop-bit cycle the next edge sets state=IDLE, Busy<=0, Done<=1 for
//    exactly one cycle. A rise present on that Done cycle is accepted, which allows back-to-back
//    frames with no idle gap.
//  - Frame length with default parameters: 1+10+1+1 = 13 bit periods.
//    Tx low to Done high = 13*CLKS_PER_BIT cycles.
//  - Tx is driven from a register, so there are no combinational glitches on the line.
// STRUCTURE
//  - Shared package/include (frame_pkg): FSM state encodings (IDLE, START, DATA, PARITY, STOP),
//    default DATA_W=10, default CLKS_PER_BIT, and localparam FRAME_BITS = 1+DATA_W+PARITY_EN+STOP_BITS.
//    The receiver and the display driver use the same package.
//  - One sub-module: bit_timer. It is a counter with parameter CLKS_PER_BIT, inputs clk, rst and
//    clear, and a one-cycle output tick on the last cycle of each bit. It is reusable by the
//    receiver for mid-bit sampling.
//  - The FSM, shift register, parity and edge detect stay in frame_tx.
// TESTING (bench uses CLKS_PER_BIT=4, DATA_W=10, PARITY_EN=1, STOP_BITS=1)
//  1. Reset held 3 cycles, tx_start=0 -> Tx=1, Busy=0, Done=0 throughout and after release.
//  2. tx_pi=10'b10_1100_0101 with a tx_start rise ->
//     Tx = 0, 1,0,1,0,0,0,1,1,0,1, parity 1, stop 1, each bit held 4 cycles.
//     Busy is high for 52 cycles. Done pulses once, on the same edge that Busy falls.
//  3. tx_pi=10'h000 -> parity bit 0. tx_pi=10'h3FF -> parity bit 0. tx_pi=10'h001 -> parity bit 1.
//  4. Second tx_start rise at cycle 10 of a frame, and tx_pi changed mid-frame ->
//     exactly one frame is sent, carrying the originally latched payload.
//  5. tx_start held high 200 cycles -> exactly one frame. A rise on the Done cycle ->
//     the next start bit follows with no idle cycle.
//  6. rst asserted during DATA bit 5 -> Tx=1 and Busy=0 on the next cycle, no Done pulse.
//     A new rise after release sends a clean full frame.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared definitions for the frame link: FSM encodings and default link parameters.
// The transmitter, receiver and display driver all import this package.
package frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } frame_state_t;

  localparam int DATA_W_DEF       = 10;
  localparam int CLKS_PER_BIT_DEF = 5208;
  localparam bit PARITY_EN_DEF    = 1'b1;
  localparam int STOP_BITS_DEF    = 1;
  localparam int FRAME_BITS       = 1 + DATA_W_DEF + int'(PARITY_EN_DEF) + STOP_BITS_DEF;

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: tick is high on the last clk cycle of every bit period.
// clear holds the count at zero so the next period starts aligned.
module bit_timer #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(CLKS_PER_BIT - 1));
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/frame_tx.sv
// Serial transmitter for the frame link: start bit, payload LSB first, optional even
// parity, stop bit(s). Tx, Busy and Done all come straight from flops.
module frame_tx
  import frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter bit PARITY_EN    = PARITY_EN_DEF,
  parameter int STOP_BITS    = STOP_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_pi,
  output logic              Tx,
  output logic              Busy,
  output logic              Done
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  frame_state_t      state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IW-1:0]     bidx_q, bidx_d;
  logic [SW-1:0]     sidx_q, sidx_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_q;
  logic              rise;
  logic              tick;

  // Timer held at zero while idle so the start bit gets a full period.
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q == ST_IDLE),
    .tick  (tick)
  );

  assign rise = tx_start & ~start_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bidx_d  = bidx_q;
    sidx_d  = sidx_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Also reached on the Done cycle, which gives back-to-back frames.
        if (rise) begin
          shreg_d = tx_pi;
          par_d   = ^tx_pi;
          bidx_d  = '0;
          sidx_d  = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bidx_q == IW'(DATA_W - 1)) begin
            if (PARITY_EN) begin
              tx_d    = par_q;
              state_d = ST_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            bidx_d  = bidx_q + 1'b1;
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (sidx_q == SW'(STOP_BITS - 1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            sidx_d = sidx_q + 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bidx_q  <= '0;
      sidx_q  <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bidx_q  <= bidx_d;
      sidx_q  <= sidx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      start_q <= tx_start;
    end
  end

  assign Tx   = tx_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_frame_tx.sv
// Directed + random bench for frame_tx; expected line waveform is built from the
// frame format (start, LSB-first data, even parity, stop) held CPB cycles per bit.
module tb_frame_tx;

  localparam int CPB = 4;
  localparam int DW  = 10;
  localparam int NB  = 1 + DW + 1 + 1;
  localparam int FL  = NB * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_start;
  logic [DW-1:0] tx_pi;
  logic          Tx, Busy, Done;

  int total = 0;
  int bad   = 0;

  frame_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .PARITY_EN(1'b1), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_pi(tx_pi),
    .Tx(Tx), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%b exp=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"}, Tx, 1'b1);
    chk({tag, "_busy"}, Busy, 1'b0);
    chk({tag, "_done"}, Done, 1'b0);
  endtask

  // Called at a negedge with tx_start low; returns at the negedge after the accept edge.
  task automatic drive_rise(input logic [DW-1:0] p);
    tx_pi    = p;
    tx_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Checks one whole frame from the first start-bit cycle through the Done cycle.
  // poke_at >= 0: extra rise and payload change at that cycle offset.
  // chain: raise tx_start during the Done cycle with payload p2.
  task automatic check_frame(input logic [DW-1:0] p, input int poke_at, input bit hold,
                             input bit chain, input logic [DW-1:0] p2);
    logic exp_bits [NB];
    exp_bits[0] = 1'b0;
    for (int b = 0; b < DW; b++) exp_bits[1+b] = p[b];
    exp_bits[DW+1] = logic'($countones(p) % 2);
    exp_bits[DW+2] = 1'b1;
    if (!hold) tx_start = 1'b0;
    for (int i = 0; i < FL; i++) begin
      if (i == poke_at) begin
        tx_start = 1'b1;
        tx_pi    = ~p;
      end
      if (poke_at >= 0 && i == poke_at + 1) tx_start = 1'b0;
      chk($sformatf("bit%0d_tx", i / CPB), Tx, exp_bits[i / CPB]);
      chk("frame_busy", Busy, 1'b1);
      chk("frame_done", Done, 1'b0);
      @(negedge clk);
    end
    chk("end_done", Done, 1'b1);
    chk("end_busy", Busy, 1'b0);
    chk("end_tx", Tx, 1'b1);
    if (chain) begin
      tx_pi    = p2;
      tx_start = 1'b1;
      @(negedge clk);
    end else begin
      @(negedge clk);
      chk_idle("post");
    end
  endtask

  initial begin
    logic [DW-1:0] p, q;
    rst      = 1'b1;
    tx_start = 1'b0;
    tx_pi    = '0;
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      chk_idle("reset");
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_idle("released");
    end

    // Reference payload from the datasheet example
    drive_rise(10'h2C5);
    check_frame(10'h2C5, -1, 1'b0, 1'b0, '0);

    // Parity corners
    drive_rise(10'h000);
    check_frame(10'h000, -1, 1'b0, 1'b0, '0);
    drive_rise(10'h3FF);
    check_frame(10'h3FF, -1, 1'b0, 1'b0, '0);
    drive_rise(10'h001);
    check_frame(10'h001, -1, 1'b0, 1'b0, '0);

    // Rise while busy plus payload change mid-frame: one frame, original payload
    p = DW'($urandom);
    drive_rise(p);
    check_frame(p, 10, 1'b0, 1'b0, '0);
    repeat (20) begin
      @(negedge clk);
      chk_idle("no_requeue");
    end

    // tx_start held high for 200 cycles: one frame only
    p = DW'($urandom);
    drive_rise(p);
    check_frame(p, -1, 1'b1, 1'b0, '0);
    repeat (200 - FL - 2) begin
      @(negedge clk);
      chk_idle("held");
    end
    tx_start = 1'b0;
    @(negedge clk);

    // Rise on the Done cycle: next start bit with no idle gap
    p = DW'($urandom);
    q = DW'($urandom);
    drive_rise(p);
    check_frame(p, -1, 1'b0, 1'b1, q);
    check_frame(q, -1, 1'b0, 1'b0, '0);

    // Reset during data bit 5 aborts the frame without Done
    p = DW'($urandom);
    drive_rise(p);
    tx_start = 1'b0;
    for (int i = 0; i <= 25; i++) begin
      chk("pre_abort_busy", Busy, 1'b1);
      if (i < 25) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk_idle("abort");
    rst = 1'b0;
    repeat (60) begin
      @(negedge clk);
      chk_idle("after_abort");
    end
    p = DW'($urandom);
    drive_rise(p);
    check_frame(p, -1, 1'b0, 1'b0, '0);

    // Random payloads
    repeat (6) begin
      p = DW'($urandom);
      drive_rise(p);
      check_frame(p, -1, 1'b0, 1'b0, '0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
